// File: rtl/dmem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-port fixed-latency memory.
// Define DMEM_ARB_RR_EN to alternate grants on simultaneous requests instead of D-over-IF priority.
module dmem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [31:0]       if_rdata,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t            state_q;
  owner_t            owner_q, pick_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              st_q;
  logic              if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic              mem_en_q, mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, if_rdata_q, d_rdata_q;
  logic              if_pend, d_pend, req_any_d;

  // A requester whose rvalid is pulsing still holds req this cycle; mask it so it is not re-issued.
  assign if_pend = if_req && !if_rvalid_q;
  assign d_pend  = d_req && !d_rvalid_q;

  always_comb begin
    req_any_d = if_pend || d_pend;
`ifdef DMEM_ARB_RR_EN
    if (if_pend && d_pend) pick_d = (owner_q == OWN_D) ? OWN_IF : OWN_D;
    else                   pick_d = d_pend ? OWN_D : OWN_IF;
`else
    pick_d = d_pend ? OWN_D : OWN_IF;
`endif
    cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_D;
      cnt_q       <= '0;
      st_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            owner_q  <= pick_d;
            state_q  <= S_ISSUE;
            mem_en_q <= 1'b1;
            if (pick_d == OWN_D) begin
              st_q        <= d_we;
              mem_we_q    <= d_we;
              mem_be_q    <= d_we ? d_be : 4'hF;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              d_gnt_q     <= 1'b1;
            end else begin
              st_q       <= 1'b0;
              mem_be_q   <= 4'hF;
              mem_addr_q <= if_addr;
              if_gnt_q   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= LAT_M1;
          state_q <= (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == 4'd0) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_q <= 1'b1;
            if (!st_q) d_rdata_q <= mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_pend;
  assign stall_mem = d_pend;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A (MEM_LATENCY=2)
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // Instance B (MEM_LATENCY=1)
  logic        if_req1, d_req1, d_we1;
  logic [31:0] if_addr1, d_addr1, d_wdata1;
  logic [3:0]  d_be1;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, stall_if1, stall_mem1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;

  dmem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  dmem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rdata(if_rdata1), .if_rvalid(if_rvalid1),
    .d_req(d_req1), .d_we(d_we1), .d_be(d_be1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rdata(d_rdata1), .d_rvalid(d_rvalid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_0013;
      32'h300: return 32'hDEAD_BEEF;
      32'h010: return 32'h1234_5678;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory model: data is valid only in the cycle exactly MEM_LATENCY after mem_en.
  logic        v2_0 = 1'b0, v2_1 = 1'b0, v1_0 = 1'b0;
  logic [31:0] a2_0 = '0, a2_1 = '0, a1_0 = '0;
  always @(posedge clk) begin
    v2_0 <= mem_en;  a2_0 <= mem_addr;
    v2_1 <= v2_0;    a2_1 <= a2_0;
    v1_0 <= mem_en1; a1_0 <= mem_addr1;
  end
  assign mem_rdata  = v2_1 ? mem_word(a2_1) : 32'hBAD0_BAD0;
  assign mem_rdata1 = v1_0 ? mem_word(a1_0) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_be1 = '0; d_addr1 = '0; d_wdata1 = '0;

    // Reset
    step(); step(); mid();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_gnt", {if_gnt, d_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    step(); rst = 1;

    // Fetch only: T
    step(); if_req = 1; if_addr = 32'h100; mid();
    chk("f_stall_T", stall_if, 1);
    chk("f_mem_en_T", mem_en, 0);
    step(); mid();  // T+1
    chk("f_gnt", if_gnt, 1);
    chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_be", mem_be, 4'hF);
    step(); mid();  // T+2
    chk("f_mem_en_off", mem_en, 0);
    chk("f_gnt_off", if_gnt, 0);
    step(); mid();  // T+3
    chk("f_rvalid_T3", if_rvalid, 0);
    chk("f_stall_T3", stall_if, 1);
    step(); mid();  // T+4
    chk("f_rvalid", if_rvalid, 1);
    chk("f_rdata", if_rdata, 32'h13);
    chk("f_stall_T4", stall_if, 0);
    step(); if_req = 0; mid();  // T+5
    chk("f_no_reissue", mem_en, 0);
    chk("f_rvalid_off", if_rvalid, 0);

    // Simultaneous: D load 0x300 first, then IF 0x104
    step(); if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_be = 4'h0; d_addr = 32'h300; mid();
    step(); mid();  // T+1
    chk("s_d_gnt", d_gnt, 1);
    chk("s_if_gnt", if_gnt, 0);
    chk("s_mem_addr", mem_addr, 32'h300);
    chk("s_load_be", mem_be, 4'hF);
    step(); step(); step(); mid();  // T+4
    chk("s_d_rvalid", d_rvalid, 1);
    chk("s_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("s_stall_if", stall_if, 1);
    step(); d_req = 0; mid();  // T+5
    chk("s_if_gnt2", if_gnt, 1);
    chk("s_d_gnt2", d_gnt, 0);
    chk("s_mem_addr2", mem_addr, 32'h104);
    step(); step(); mid();  // T+7
    chk("s_if_rvalid_T7", if_rvalid, 0);
    step(); mid();  // T+8
    chk("s_if_rvalid", if_rvalid, 1);
    chk("s_if_rdata", if_rdata, 32'hA5A5_0104);
    step(); if_req = 0; mid();

    // Store SB
    step(); d_req = 1; d_we = 1; d_be = 4'b0100; d_addr = 32'h204; d_wdata = 32'h00AB_0000; mid();
    step(); mid();  // T+1
    chk("sb_gnt", d_gnt, 1);
    chk("sb_mem_we", mem_we, 1);
    chk("sb_mem_be", mem_be, 4'b0100);
    chk("sb_mem_wdata", mem_wdata, 32'h00AB_0000);
    chk("sb_mem_addr", mem_addr, 32'h204);
    step(); mid();  // T+2
    chk("sb_we_off", mem_we, 0);
    chk("sb_be_hold", mem_be, 4'b0100);
    step(); mid();  // T+3
    chk("sb_stall", stall_mem, 1);
    step(); mid();  // T+4
    chk("sb_rvalid", d_rvalid, 1);
    chk("sb_rdata_kept", d_rdata, 32'hDEAD_BEEF);
    chk("sb_stall_off", stall_mem, 0);
    step(); d_req = 0; mid();

    // Fetch dropped after grant
    step(); if_req = 1; if_addr = 32'h108; mid();
    step(); mid();  // T+1
    chk("dr_gnt", if_gnt, 1);
    step(); if_req = 0; mid();  // T+2
    chk("dr_stall", stall_if, 0);
    step(); step(); mid();  // T+4
    chk("dr_rvalid", if_rvalid, 1);
    chk("dr_rdata", if_rdata, 32'hA5A5_0108);
    step(); mid();  // T+5
    chk("dr_no_second", mem_en, 0);

    // Store with no byte enables
    step(); d_req = 1; d_we = 1; d_be = 4'h0; d_addr = 32'h20C; d_wdata = 32'hFFFF_FFFF; mid();
    step(); mid();  // T+1
    chk("be0_en", mem_en, 1);
    chk("be0_we", mem_we, 1);
    chk("be0_be", mem_be, 4'h0);
    step(); step(); step(); mid();  // T+4
    chk("be0_rvalid", d_rvalid, 1);
    step(); d_req = 0; mid();

    // Reset one cycle after ISSUE, request held across reset
    step(); d_req = 1; d_we = 0; d_addr = 32'h300; mid();
    step(); mid();  // T+1 ISSUE
    chk("rw_gnt", d_gnt, 1);
    step(); rst = 0; mid();  // T+2
    step(); rst = 1; mid();  // T+3
    chk("rw_mem_en", mem_en, 0);
    chk("rw_rvalid", d_rvalid, 0);
    chk("rw_rdata_clr", d_rdata, 0);
    step(); mid();  // T+4
    chk("rw_no_old_rvalid", d_rvalid, 0);
    chk("rw_regnt", d_gnt, 1);
    chk("rw_mem_addr", mem_addr, 32'h300);
    step(); step(); step(); mid();  // T+7
    chk("rw_rvalid2", d_rvalid, 1);
    chk("rw_rdata2", d_rdata, 32'hDEAD_BEEF);
    step(); d_req = 0; mid();

    // MEM_LATENCY=1 load
    step(); d_req1 = 1; d_we1 = 0; d_addr1 = 32'h10; mid();
    step(); mid();  // T+1
    chk("l1_gnt", d_gnt1, 1);
    chk("l1_en", mem_en1, 1);
    step(); mid();  // T+2
    chk("l1_rvalid_T2", d_rvalid1, 0);
    step(); mid();  // T+3
    chk("l1_rvalid", d_rvalid1, 1);
    chk("l1_rdata", d_rdata1, 32'h1234_5678);
    step(); d_req1 = 0; mid();
    chk("l1_idle", mem_en1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
